// File: rtl/alu_seq_muldiv.sv
// Registered EX-stage ALU: single-cycle ops plus iterative unsigned multiply/divide
// behind a valid/ready handshake.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fin;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign accept  = valid_i & ready_o;
    assign ready_o = (state == IDLE);
    assign zero_o  = (result_o == '0);
    assign sum     = src1_i + src2_i;
    assign diff    = src1_i - src2_i;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_NOR:  alu_res = ~(src1_i | src2_i);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
            default: ;
        endcase
    end

    // One shift-add step: {hi,lo} shifts right, multiplier bit consumed from lo[0]
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

    // One restoring step: remainder in hi, dividend shifts out of lo as quotient shifts in
    logic [WIDTH:0]   div_shift;
    logic             div_geq;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_geq   = div_shift >= {1'b0, opb};
    assign div_sub   = div_shift[WIDTH-1:0] - opb;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            fin      <= 1'b0;
            opb      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            hi_o     <= '0;
            ovf_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (ctrl_i == OP_MULTU || ctrl_i == OP_DIVU) begin
                        state  <= (ctrl_i == OP_MULTU) ? MUL : DIV;
                        cnt    <= CNT_W'(WIDTH-1);
                        fin    <= 1'b0;
                        acc_hi <= '0;
                        acc_lo <= (ctrl_i == OP_MULTU) ? src2_i : src1_i;
                        opb    <= (ctrl_i == OP_MULTU) ? src1_i : src2_i;
                    end else begin
                        result_o <= alu_res;
                        hi_o     <= '0;
                        ovf_o    <= alu_ovf;
                        valid_o  <= 1'b1;
                    end
                end
                MUL, DIV: begin
                    // fin marks that the counter==0 iteration has been applied; publish next edge
                    if (fin) begin
                        result_o <= acc_lo;
                        hi_o     <= acc_hi;
                        ovf_o    <= 1'b0;
                        valid_o  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        if (state == MUL) begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end else begin
                            acc_hi <= div_geq ? div_sub : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_geq};
                        end
                        cnt <= cnt - 1'b1;
                        fin <= (cnt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv: single-cycle ops, back-to-back issue,
// multi-cycle MULTU/DIVU latency, busy-time input masking and reset abort.
module tb_alu_seq_muldiv;

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic        zero_o;
    logic        ovf_o;

    int total = 0;
    int bad   = 0;
    int cyc;
    int low;
    bit held;
    int stray;

    alu_seq_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready_o), .valid_o(valid_o),
        .result_o(result_o), .hi_o(hi_o), .zero_o(zero_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i = 1'b1;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Issue a long op, keep valid_i high with an ADD throughout, wait (bounded) for valid_o.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int n, output int lo_cnt, output bit hold_ok);
        logic [31:0] r0, h0;
        r0 = result_o;
        h0 = hi_o;
        drive(op, a, b);
        step;
        chk("busy_ready_after_accept", ready_o, 1'b0);
        ctrl_i = OP_ADD;
        src1_i = 32'd1;
        src2_i = 32'd1;
        n = 0; lo_cnt = 0; hold_ok = 1'b1;
        while (!valid_o && n < 40) begin
            step;
            n++;
            if (!valid_o) begin
                if (!ready_o) lo_cnt++;
                if (result_o !== r0 || hi_o !== h0) hold_ok = 1'b0;
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0;
        // Reset wins over a request in the same cycle
        drive(OP_ADD, 32'd5, 32'd7);
        step; step;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_zero", zero_o, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_i = 1'b0;

        drive(OP_ADD, 32'd5, 32'd7);
        step;
        chk("add_valid", valid_o, 1'b1);
        chk("add_result", result_o, 32'd12);
        chk("add_zero", zero_o, 1'b0);
        chk("add_ovf", ovf_o, 1'b0);
        chk("add_hi", hi_o, 32'd0);

        drive(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        step;
        chk("sub_ovf_result", result_o, 32'h8000_0000);
        chk("sub_ovf_flag", ovf_o, 1'b1);
        drive(OP_SUB, 32'd3, 32'd3);
        step;
        chk("sub_b2b_valid", valid_o, 1'b1);
        chk("sub_b2b_result", result_o, 32'd0);
        chk("sub_b2b_zero", zero_o, 1'b1);
        chk("sub_b2b_ovf", ovf_o, 1'b0);

        drive(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        step;
        chk("slt_result", result_o, 32'd1);
        drive(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        step;
        chk("sltu_result", result_o, 32'd0);
        drive(OP_ADD, 32'd9, 32'd9);
        step;
        drive(4'b1111, 32'h1234, 32'h5678);
        step;
        chk("bad_op_valid", valid_o, 1'b1);
        chk("bad_op_result", result_o, 32'd0);
        chk("bad_op_hi", hi_o, 32'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        step;
        chk("idle_no_valid", valid_o, 1'b0);

        run_long(OP_MULTU, 32'hFFFF_FFFF, 32'd2, cyc, low, held);
        chk("mul_latency", cyc, 33);
        chk("mul_ready_low_cycles", low, 32);
        chk("mul_outputs_held", held, 1'b1);
        chk("mul_ready_done", ready_o, 1'b1);
        chk("mul_result", result_o, 32'hFFFF_FFFE);
        chk("mul_hi", hi_o, 32'd1);
        chk("mul_ovf", ovf_o, 1'b0);
        step;
        chk("mul_busy_req_dropped", valid_o, 1'b0);
        chk("mul_result_kept", result_o, 32'hFFFF_FFFE);

        run_long(OP_DIVU, 32'd100, 32'd7, cyc, low, held);
        chk("div_latency", cyc, 33);
        chk("div_result", result_o, 32'd14);
        chk("div_hi", hi_o, 32'd2);

        run_long(OP_DIVU, 32'd9, 32'd0, cyc, low, held);
        chk("div0_latency", cyc, 33);
        chk("div0_result", result_o, 32'hFFFF_FFFF);
        chk("div0_hi", hi_o, 32'd9);

        // Abort a multiply with reset on its tenth cycle
        drive(OP_MULTU, 32'd3, 32'd5);
        step;
        valid_i = 1'b0;
        repeat (9) step;
        chk("abort_still_busy", ready_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_valid", valid_o, 1'b0);
        chk("abort_result", result_o, 32'd0);
        chk("abort_hi", hi_o, 32'd0);
        chk("abort_ready", ready_o, 1'b1);
        chk("abort_zero", zero_o, 1'b1);
        stray = 0;
        repeat (40) begin
            step;
            if (valid_o) stray++;
        end
        chk("abort_no_late_valid", stray, 0);

        drive(OP_ADD, 32'd1, 32'd1);
        step;
        chk("post_abort_add_valid", valid_o, 1'b1);
        chk("post_abort_add_result", result_o, 32'd2);
        @(negedge clk_i);
        valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
